obi_mem_arbiter: RTL and testbench

- Two-host to one-device OBI arbiter that shares a single unified memory port between instruction fetch (host 0) and the memory stage's dmem driver (host 1).
- Address phase is a combinational pass-through with round-robin selection and a stability lock.
- Response phase is routed back to the originating host using an in-order FIFO of outstanding host IDs.
- Sits between the core's two OBI host drivers and the SoC memory/interconnect.

---
 rtl/obi_mem_arbiter_pkg.sv | 18 +
 rtl/obi_id_fifo.sv | 81 ++++++++
 rtl/obi_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_mem_arbiter_pkg.sv
// Shared definitions for the two-host OBI memory arbiter: host identifiers
// and a small helper used by the round-robin priority logic.
package obi_mem_arbiter_pkg;

  // Host 0 is instruction fetch, host 1 is the memory stage's dmem driver.
  typedef enum logic {
    HOST_IMEM = 1'b0,
    HOST_DMEM = 1'b1
  } host_id_e;

  localparam int unsigned HOST_ID_W = 1;

  // The host that should get priority after `h` has been served.
  function automatic host_id_e other_host(input host_id_e h);
    return (h == HOST_IMEM) ? HOST_DMEM : HOST_IMEM;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// Small synchronous-reset FIFO holding the IDs of outstanding transactions.
// Pushes while full and pops while empty are ignored.
module obi_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap at DEPTH, which need not fill the pointer's binary range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; empty slots are never observed.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-host to one-device OBI arbiter. The address phase is a combinational
// pass-through with round-robin selection and a lock that holds the chosen
// host until the device grants; responses are steered back in order using
// a FIFO of outstanding host IDs.
module obi_mem_arbiter
  import obi_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                h0_req_i,
  output logic                h0_gnt_o,
  input  logic [ADDR_W-1:0]   h0_addr_i,
  input  logic                h0_we_i,
  input  logic [DATA_W/8-1:0] h0_be_i,
  input  logic [DATA_W-1:0]   h0_wdata_i,
  output logic                h0_rvalid_o,
  output logic [DATA_W-1:0]   h0_rdata_o,

  input  logic                h1_req_i,
  output logic                h1_gnt_o,
  input  logic [ADDR_W-1:0]   h1_addr_i,
  input  logic                h1_we_i,
  input  logic [DATA_W/8-1:0] h1_be_i,
  input  logic [DATA_W-1:0]   h1_wdata_i,
  output logic                h1_rvalid_o,
  output logic [DATA_W-1:0]   h1_rdata_o,

  output logic                dev_req_o,
  input  logic                dev_gnt_i,
  output logic [ADDR_W-1:0]   dev_addr_o,
  output logic                dev_we_o,
  output logic [DATA_W/8-1:0] dev_be_o,
  output logic [DATA_W-1:0]   dev_wdata_o,
  input  logic                dev_rvalid_i,
  input  logic [DATA_W-1:0]   dev_rdata_i,

  output logic                busy_o,
  output logic                proto_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  host_id_e               sel;
  host_id_e               prio_q, prio_d;
  host_id_e               lock_host_q, lock_host_d;
  logic                   lock_q, lock_d;
  logic                   proto_err_q, proto_err_d;
  logic                   sel_req;
  logic                   accept;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic [HOST_ID_W-1:0]   fifo_head;
  logic [CNT_W-1:0]       fifo_count;
  host_id_e               head_host;

  // Host selection: a pending (ungranted) request keeps its host, otherwise
  // the lone requester wins, and a tie goes to the round-robin priority.
  always_comb begin
    sel = HOST_IMEM;
    if (lock_q) begin
      sel = lock_host_q;
    end else if (h0_req_i && !h1_req_i) begin
      sel = HOST_IMEM;
    end else if (h1_req_i && !h0_req_i) begin
      sel = HOST_DMEM;
    end else if (h0_req_i && h1_req_i) begin
      sel = prio_q;
    end
  end

  assign sel_req   = (sel == HOST_DMEM) ? h1_req_i : h0_req_i;
  // A full ID FIFO blocks new requests even if a response pops it this cycle.
  assign dev_req_o = sel_req & ~fifo_full;
  assign accept    = dev_req_o & dev_gnt_i;

  assign h0_gnt_o  = accept & (sel == HOST_IMEM);
  assign h1_gnt_o  = accept & (sel == HOST_DMEM);

  // Address-phase mux; host 0 is forwarded when nobody is selected.
  always_comb begin
    if (sel == HOST_DMEM) begin
      dev_addr_o  = h1_addr_i;
      dev_we_o    = h1_we_i;
      dev_be_o    = h1_be_i;
      dev_wdata_o = h1_wdata_i;
    end else begin
      dev_addr_o  = h0_addr_i;
      dev_we_o    = h0_we_i;
      dev_be_o    = h0_be_i;
      dev_wdata_o = h0_wdata_i;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (HOST_ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Responses go to the oldest outstanding host; data is broadcast.
  assign pop         = dev_rvalid_i & ~fifo_empty;
  assign head_host   = host_id_e'(fifo_head);
  assign h0_rvalid_o = pop & (head_host == HOST_IMEM);
  assign h1_rvalid_o = pop & (head_host == HOST_DMEM);
  assign h0_rdata_o  = dev_rdata_i;
  assign h1_rdata_o  = dev_rdata_i;

  assign busy_o      = (fifo_count != '0);
  assign proto_err_o = proto_err_q;

  // Next state for priority, lock and the protocol-error flag. The lock only
  // lives while a request is waiting for grant, so a host that withdraws a
  // request (illegal, but possible) cannot wedge the arbiter.
  always_comb begin
    prio_d      = prio_q;
    lock_d      = 1'b0;
    lock_host_d = lock_host_q;
    if (accept) begin
      prio_d = other_host(sel);
    end
    if (dev_req_o && !dev_gnt_i) begin
      lock_d      = 1'b1;
      lock_host_d = sel;
    end
    proto_err_d = dev_rvalid_i & fifo_empty;
  end

  // Arbitration state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= HOST_IMEM;
      lock_q      <= 1'b0;
      lock_host_q <= HOST_IMEM;
      proto_err_q <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      lock_q      <= lock_d;
      lock_host_q <= lock_host_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter with a cycle-level reference model of
// the arbitration rules and an in-order queue of outstanding host IDs.
module tb_obi_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          h0_req, h1_req, h0_we, h1_we;
  logic [AW-1:0] h0_addr, h1_addr;
  logic [DW/8-1:0] h0_be, h1_be;
  logic [DW-1:0] h0_wdata, h1_wdata;
  logic          h0_gnt, h1_gnt, h0_rvalid, h1_rvalid;
  logic [DW-1:0] h0_rdata, h1_rdata;
  logic          dev_req, dev_gnt, dev_we, dev_rvalid;
  logic [AW-1:0] dev_addr;
  logic [DW/8-1:0] dev_be;
  logic [DW-1:0] dev_wdata, dev_rdata;
  logic          busy, proto_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .h0_req_i(h0_req), .h0_gnt_o(h0_gnt), .h0_addr_i(h0_addr), .h0_we_i(h0_we),
    .h0_be_i(h0_be), .h0_wdata_i(h0_wdata), .h0_rvalid_o(h0_rvalid), .h0_rdata_o(h0_rdata),
    .h1_req_i(h1_req), .h1_gnt_o(h1_gnt), .h1_addr_i(h1_addr), .h1_we_i(h1_we),
    .h1_be_i(h1_be), .h1_wdata_i(h1_wdata), .h1_rvalid_o(h1_rvalid), .h1_rdata_o(h1_rdata),
    .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
    .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
    .busy_o(busy), .proto_err_o(proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_q[$];        // outstanding host IDs, oldest first
  bit m_prio;        // host that wins a tie
  bit m_wait_v;      // a request is waiting for grant
  bit m_wait_h;      // ...from this host
  bit m_perr;        // expected proto_err_o
  bit started = 0;

  function automatic bit m_sel();
    if (m_wait_v) return m_wait_h;
    if (h0_req && !h1_req) return 1'b0;
    if (h1_req && !h0_req) return 1'b1;
    if (h0_req && h1_req) return m_prio;
    return 1'b0;
  endfunction

  function automatic bit m_req();
    bit s = m_sel();
    bit r = s ? h1_req : h0_req;
    return r && (m_q.size() < MO);
  endfunction

  always @(posedge clk) begin
    bit s, r, pop;
    s = m_sel();
    r = m_req();
    pop = dev_rvalid && (m_q.size() > 0);
    if (rst) begin
      m_q.delete();
      m_prio = 1'b0; m_wait_v = 1'b0; m_wait_h = 1'b0; m_perr = 1'b0;
      started = 1'b1;
    end else begin
      m_perr = dev_rvalid && (m_q.size() == 0);
      if (pop) void'(m_q.pop_front());
      if (r && dev_gnt) begin
        m_q.push_back(s);
        m_prio = !s;
      end
      m_wait_v = r && !dev_gnt;
      if (m_wait_v) m_wait_h = s;
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      bit s, r, pv;
      s  = m_sel();
      r  = m_req();
      pv = dev_rvalid && (m_q.size() > 0);
      chk("dev_req", dev_req, r);
      chk("h0_gnt", h0_gnt, r && dev_gnt && !s);
      chk("h1_gnt", h1_gnt, r && dev_gnt && s);
      chk("dev_addr", dev_addr, s ? h1_addr : h0_addr);
      chk("dev_we", dev_we, s ? h1_we : h0_we);
      chk("dev_be", 64'(dev_be), 64'(s ? h1_be : h0_be));
      chk("dev_wdata", dev_wdata, s ? h1_wdata : h0_wdata);
      chk("h0_rvalid", h0_rvalid, pv && (m_q[0] == 1'b0));
      chk("h1_rvalid", h1_rvalid, pv && (m_q[0] == 1'b1));
      chk("h0_rdata", h0_rdata, dev_rdata);
      chk("h1_rdata", h1_rdata, dev_rdata);
      chk("busy", busy, m_q.size() != 0);
      chk("proto_err", proto_err, m_perr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h0_req = 0; h1_req = 0; dev_gnt = 0; dev_rvalid = 0;
  endtask

  initial begin
    rst = 1; idle();
    h0_addr = 64'h100; h1_addr = 64'h200; h0_we = 0; h1_we = 0;
    h0_be = 8'hFF; h1_be = 8'h0F; h0_wdata = 64'h11; h1_wdata = 64'h22;
    dev_rdata = 64'h0;
    cyc(); cyc();
    rst = 0;
    #2;
    chk("rst dev_req", dev_req, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst proto_err", proto_err, 1'b0);
    chk("rst gnts", {h0_gnt, h1_gnt}, 2'b00);

    // Single host write from h1.
    cyc();
    h1_req = 1; h1_we = 1; h1_addr = 64'h1000; h1_be = 8'hFF; h1_wdata = 64'hCAFE; dev_gnt = 1;
    #2;
    chk("t1 h1_gnt", h1_gnt, 1'b1);
    chk("t1 h0_gnt", h0_gnt, 1'b0);
    chk("t1 dev_addr", dev_addr, 64'h1000);
    cyc();
    idle(); dev_rvalid = 1; dev_rdata = 64'h55;
    #2;
    chk("t1 h1_rvalid", h1_rvalid, 1'b1);
    chk("t1 h0_rvalid", h0_rvalid, 1'b0);
    chk("t1 busy", busy, 1'b1);
    cyc();
    idle(); h1_we = 0;
    #2;
    chk("t1 busy after", busy, 1'b0);

    // Round-robin with both hosts requesting, response each following cycle.
    for (int i = 0; i < 4; i++) begin
      cyc();
      h0_req = 1; h1_req = 1; dev_gnt = 1;
      dev_rvalid = (i > 0); dev_rdata = 64'hA0 + 64'(i);
      #2;
      chk("rr h0_gnt", h0_gnt, (i % 2) == 0);
      chk("rr h1_gnt", h1_gnt, (i % 2) == 1);
      if (i > 0) chk("rr rvalid route", {h0_rvalid, h1_rvalid}, (i % 2) ? 2'b10 : 2'b01);
    end
    cyc();
    idle(); dev_rvalid = 1;
    #2;
    chk("rr last rvalid h1", h1_rvalid, 1'b1);
    cyc();
    idle();

    // Lock: h0 pending without grant while h1 wiggles its address.
    h0_addr = 64'h4000; h1_addr = 64'h5000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      h0_req = 1; h1_req = 1; dev_gnt = 0;
      h1_addr = 64'h5000 + 64'(i * 8);
      #2;
      chk("lock dev_addr", dev_addr, 64'h4000);
      chk("lock dev_req", dev_req, 1'b1);
    end
    cyc();
    dev_gnt = 1; h1_addr = 64'h6000;
    #2;
    chk("lock h0_gnt", h0_gnt, 1'b1);
    chk("lock h1_gnt", h1_gnt, 1'b0);
    cyc();
    idle(); dev_rvalid = 1;
    cyc();
    idle();

    // Full: two grants with no response, third request blocked.
    cyc();
    h0_req = 1; dev_gnt = 1;
    cyc();
    cyc();
    #2;
    chk("full dev_req", dev_req, 1'b0);
    chk("full h0_gnt", h0_gnt, 1'b0);
    cyc();
    dev_rvalid = 1;
    #2;
    chk("full pop blocks", dev_req, 1'b0);
    chk("full h0_rvalid", h0_rvalid, 1'b1);
    cyc();
    dev_rvalid = 0;
    #2;
    chk("full regrant", h0_gnt, 1'b1);
    cyc();
    idle(); dev_rvalid = 1;
    cyc();
    cyc();
    idle();

    // Ordering: h0 read then h1 read, responses 0xA then 0xB.
    cyc();
    h0_req = 1; h0_we = 0; dev_gnt = 1;
    cyc();
    h0_req = 0; h1_req = 1; h1_we = 0;
    #2;
    chk("ord h1_gnt", h1_gnt, 1'b1);
    cyc();
    idle(); dev_rvalid = 1; dev_rdata = 64'hA;
    #2;
    chk("ord h0_rvalid", h0_rvalid, 1'b1);
    chk("ord h0_rdata", h0_rdata, 64'hA);
    cyc();
    dev_rvalid = 1; dev_rdata = 64'hB;
    #2;
    chk("ord h1_rvalid", h1_rvalid, 1'b1);
    chk("ord h0 quiet", h0_rvalid, 1'b0);
    chk("ord h1_rdata", h1_rdata, 64'hB);
    cyc();
    idle();

    // Reset with one transaction outstanding (priority had moved to h1).
    cyc();
    h0_req = 1; dev_gnt = 1;
    cyc();
    idle(); rst = 1;
    cyc();
    rst = 0; dev_rvalid = 1;
    #2;
    chk("rst drop rvalid", {h0_rvalid, h1_rvalid}, 2'b00);
    chk("rst busy low", busy, 1'b0);
    cyc();
    dev_rvalid = 0;
    #2;
    chk("rst proto_err pulse", proto_err, 1'b1);
    cyc();
    h0_req = 1; h1_req = 1; dev_gnt = 1;
    #2;
    chk("rst proto_err clear", proto_err, 1'b0);
    chk("rst prio h0", h0_gnt, 1'b1);
    cyc();
    idle(); dev_rvalid = 1;
    cyc();
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
